addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined integer adder/subtractor with valid/ready handshakes on both sides. Operands are split into CHUNK-bit slices. One slice is summed per pipeline stage and the carry is registered between stages, so throughput is one operation per cycle at any WIDTH. Besides plain add/sub, it provides signed-saturating add/sub, carry, overflow and zero flags. It is the execution-side arithmetic block; the producer drives the input handshake and the consumer drives `out_ready`.

## Interface
- `WIDTH`, 32: operand/result width in bits; must be a multiple of CHUNK.
- `CHUNK`, 8: bits summed per stage; STAGES = WIDTH/CHUNK (≥1).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts the beat this cycle.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `op`  in  2  00 ADD, 01 SUB, 10 ADDSAT, 11 SUBSAT.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result.
- `carry`  out  1  raw carry-out of a + b' + cin. For SUB ops, 1 means no borrow (a ≥ b unsigned).
- `overflow`  out  1  signed overflow of the unsaturated result.
- `zero`  out  1  final `sum` == 0.

## Operation
- Transfer occurs on a cycle where valid and ready are both high. Input transfer is `in_valid && in_ready`; output transfer is `out_valid && out_ready`.
- Operand preparation:
  - For SUB and SUBSAT, b' = ~b and cin = 1.
  - For ADD and ADDSAT, b' = b and cin = 0.
- Stage k (0..STAGES-1) computes slice k of a + b' + carry_in(k) as CHUNK+1 bits and registers the slice plus carry_out.
  - Upper operand slices and op travel with the beat.
  - Lower result slices travel with the beat as well.
- Final stage:
  - `carry` = carry_out of the top slice.
  - `overflow` = (a[MSB] == b'[MSB]) && (raw[MSB] != a[MSB]).
  - For ADDSAT/SUBSAT with overflow: sum = a[MSB] ? 100…0 : 011…1.
  - Otherwise sum = raw.
  - `zero` is computed on the final (post-saturation) `sum`.
- Stall rule, per stage: stage k captures when `!valid_k || ready_{k+1}`. Ready of the last stage is `out_ready`. `in_ready` = ready of stage 0.
- Stall behaviour:
  - A full pipeline with `out_ready`=0 holds all data and drops `in_ready`.
  - Bubbles collapse while the output is stalled.
- Ordering and hold:
  - Results emerge in acceptance order with no loss or duplication.
  - `sum`/flags stay stable while `out_valid && !out_ready`.
- Simultaneous events: input and output transfers in the same cycle are both honoured. A full pipeline with `out_ready`=1 accepts a new beat in that cycle.
- Reset:
  - Asynchronously clears all stage valid bits.
  - Outputs: `out_valid`=0, `sum`=0, `carry`=0, `overflow`=0, `zero`=0.
  - `in_ready`=1 while reset is high and after release.
  - Beats in flight at reset are discarded.

## Timing
- Latency from input transfer to `out_valid` is STAGES cycles when unstalled (WIDTH=32, CHUNK=8 → 4).
- Throughput is 1 beat/cycle sustained with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready` through the stage valid bits. There is no combinational path from `a`/`b`/`op` to any output.
- Critical path per stage is one CHUNK-bit add, plus the saturation mux in the last stage.

## Structure
- Shared header `addsub_defs.vh` holds:
  - op encodings `OP_ADD`, `OP_SUB`, `OP_ADDSAT`, `OP_SUBSAT`.
  - the default WIDTH/CHUNK values.
- Sub-module `addsub_stage` implements one pipeline slot: slice adder, carry register, valid/ready logic, beat payload register. Parameters: stage index, WIDTH, CHUNK.
- Top level `addsub_pipe` generates STAGES instances and adds operand preparation and final saturation/flag logic.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- **Basic add:** ADD 0x00000001 + 0x00000002 with `out_ready`=1 → after 4 cycles `sum`=0x00000003, carry=0, overflow=0, zero=0.
- **Carry across slices:** ADD 0x00FFFFFF + 0x00000001 → 0x01000000, carry=0. ADD 0xFFFFFFFF + 1 → 0x00000000, carry=1, zero=1, overflow=0.
- **Subtraction:**
  - SUB 5 − 7 → 0xFFFFFFFE, carry=0.
  - SUB 7 − 7 → 0, carry=1, zero=1.
  - SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow=1.
- **Saturation:**
  - ADD 0x7FFFFFFF + 1 → 0x80000000, overflow=1.
  - ADDSAT, same operands → 0x7FFFFFFF, overflow=1.
  - SUBSAT 0x80000000 − 1 → 0x80000000.
  - ADDSAT 3 + 4 → 7, overflow=0.
- **Backpressure stream:** 32 random ops back-to-back with `out_ready` randomly toggled.
  - All results match the reference model, in order, with none lost or duplicated.
  - Output holds stable while stalled.
  - `in_ready` falls after 4 beats accepted with `out_ready`=0.
- **Reset mid-stream:** assert `reset` asynchronously with 3 beats in flight.
  - `out_valid`=0 immediately and stays 0 after release until new beats arrive.
  - Flags are 0 and `in_ready`=1.
  - The first post-reset beat emerges 4 cycles after acceptance.

Source files
------------

// File: rtl/addsub_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe_pkg
// Purpose  : Shared definitions for the pipelined adder/subtractor:
//            operation encodings, default geometry and small op decoders.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_ADDSAT = 2'b10,
    OP_SUBSAT = 2'b11
  } op_e;

  localparam int c_DEF_WIDTH = 32;
  localparam int c_DEF_CHUNK = 8;

  // Bit 0 of the encoding selects subtraction (invert b, carry-in of 1).
  function automatic logic op_is_sub(input op_e op);
    logic [1:0] v;
    v = op;
    return v[0];
  endfunction

  // Bit 1 of the encoding selects signed saturation of the result.
  function automatic logic op_is_sat(input op_e op);
    logic [1:0] v;
    v = op;
    return v[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe_if
// Purpose  : Operand/result handshake bundle for addsub_pipe.
// Signals  : in_valid/in_ready, a, b, op        - operand beat
//            out_valid/out_ready, sum, carry,
//            overflow, zero                       - result beat
// Modports : master - producer/consumer side, slave - arithmetic block
// Revision : 1.0 - initial release
// ============================================================================
interface addsub_pipe_if
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero
  );

endinterface
`default_nettype wire

// File: rtl/addsub_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : addsub_stage
// Purpose  : One pipeline slot. Adds slice STAGE_IDX of a + b' + carry-in,
//            merges it into the partial result and registers the whole beat
//            (operands, partial result, carry-out, op) behind a valid/ready
//            skid-free handshake.
// Ports    : clk, reset              - clock, async active-high reset
//            i_valid/o_ready         - upstream handshake
//            i_a, i_bp, i_res, i_cin,
//            i_op                    - incoming beat payload
//            o_valid/i_ready         - downstream handshake
//            o_a, o_bp, o_res,
//            o_carry, o_op           - registered beat payload
// Revision : 1.0 - initial release
// ============================================================================
module addsub_stage
  import addsub_pipe_pkg::*;
#(
  parameter int STAGE_IDX = 0,
  parameter int WIDTH     = c_DEF_WIDTH,
  parameter int CHUNK     = c_DEF_CHUNK
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_valid,
  output logic                  o_ready,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_bp,
  input  wire logic [WIDTH-1:0] i_res,
  input  wire logic             i_cin,
  input  op_e                   i_op,
  output logic                  o_valid,
  input  wire logic             i_ready,
  output logic [WIDTH-1:0]      o_a,
  output logic [WIDTH-1:0]      o_bp,
  output logic [WIDTH-1:0]      o_res,
  output logic                  o_carry,
  output op_e                   o_op
);

  localparam int c_LO = STAGE_IDX * CHUNK;

  logic [CHUNK:0]   w_slice;
  logic [WIDTH-1:0] w_res;

  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bp;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  op_e              r_op;

  // CHUNK+1 bit sum so the slice carry-out falls out of the top bit.
  assign w_slice = {1'b0, i_a[c_LO +: CHUNK]}
                 + {1'b0, i_bp[c_LO +: CHUNK]}
                 + {{CHUNK{1'b0}}, i_cin};

  always_comb begin
    w_res                  = i_res;
    w_res[c_LO +: CHUNK]   = w_slice[CHUNK-1:0];
  end

  // An empty slot, or one whose content leaves this cycle, can take a beat.
  // This is what lets bubbles collapse while the output is stalled.
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_bp    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_op    <= OP_ADD;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_a     <= i_a;
        r_bp    <= i_bp;
        r_res   <= w_res;
        r_carry <= w_slice[CHUNK];
        r_op    <= i_op;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_bp    = r_bp;
  assign o_res   = r_res;
  assign o_carry = r_carry;
  assign o_op    = r_op;

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe
// Purpose  : Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per
//            stage with the carry registered between stages. Supports plain
//            and signed-saturating add/sub with carry, overflow and zero
//            flags. Throughput one beat per cycle, latency WIDTH/CHUNK.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset
//            bus    - addsub_pipe_if.slave (operand and result handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int CHUNK = c_DEF_CHUNK
) (
  input wire logic      clk,
  input wire logic      reset,
  addsub_pipe_if.slave  bus
);

  localparam int c_STAGES = WIDTH / CHUNK;

  // Index 0 is the prepared input beat, index k+1 is the output of stage k.
  logic             w_valid [0:c_STAGES];
  logic             w_ready [0:c_STAGES];
  logic             w_cy    [0:c_STAGES];
  logic [WIDTH-1:0] w_a     [0:c_STAGES];
  logic [WIDTH-1:0] w_bp    [0:c_STAGES];
  logic [WIDTH-1:0] w_res   [0:c_STAGES];
  op_e              w_op    [0:c_STAGES];

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_sum;
  logic             w_a_msb;
  logic             w_bp_msb;
  logic             w_ovf;
  logic             w_unused;

  // Operand preparation: subtraction is a + ~b + 1.
  assign w_valid[0] = bus.in_valid;
  assign w_a[0]     = bus.a;
  assign w_bp[0]    = op_is_sub(bus.op) ? ~bus.b : bus.b;
  assign w_cy[0]    = op_is_sub(bus.op);
  assign w_res[0]   = '0;
  assign w_op[0]    = bus.op;
  assign bus.in_ready = w_ready[0];

  assign w_ready[c_STAGES] = bus.out_ready;

  generate
    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
      addsub_stage #(
        .STAGE_IDX (k),
        .WIDTH     (WIDTH),
        .CHUNK     (CHUNK)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_valid[k]),
        .o_ready (w_ready[k]),
        .i_a     (w_a[k]),
        .i_bp    (w_bp[k]),
        .i_res   (w_res[k]),
        .i_cin   (w_cy[k]),
        .i_op    (w_op[k]),
        .o_valid (w_valid[k+1]),
        .i_ready (w_ready[k+1]),
        .o_a     (w_a[k+1]),
        .o_bp    (w_bp[k+1]),
        .o_res   (w_res[k+1]),
        .o_carry (w_cy[k+1]),
        .o_op    (w_op[k+1])
      );
    end
  endgenerate

  // Final flags and saturation, all from registered last-stage state.
  assign w_raw    = w_res[c_STAGES];
  assign w_a_msb  = w_a[c_STAGES][WIDTH-1];
  assign w_bp_msb = w_bp[c_STAGES][WIDTH-1];
  assign w_ovf    = (w_a_msb == w_bp_msb) && (w_raw[WIDTH-1] != w_a_msb);
  assign w_sat    = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_sum    = (op_is_sat(w_op[c_STAGES]) && w_ovf) ? w_sat : w_raw;

  // Result and flags are forced to zero when no beat is presented, so the
  // post-reset output state is all zeros (including the zero flag).
  assign bus.out_valid = w_valid[c_STAGES];
  assign bus.sum       = w_valid[c_STAGES] ? w_sum : '0;
  assign bus.carry     = w_valid[c_STAGES] & w_cy[c_STAGES];
  assign bus.overflow  = w_valid[c_STAGES] & w_ovf;
  assign bus.zero      = w_valid[c_STAGES] & (w_sum == '0);

  // Only the sign bits of the carried operands matter at the output.
  assign w_unused = ^{w_a[c_STAGES][WIDTH-2:0], w_bp[c_STAGES][WIDTH-2:0]};

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_pipe
// Purpose  : Scoreboard bench for addsub_pipe (WIDTH=32, CHUNK=8). Stimulus
//            pushes expected results into a queue; a monitor pops and
//            compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;
  import addsub_pipe_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
    int           acc;
    bit           lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W)) bus ();

  addsub_pipe #(.WIDTH(W), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o,
                              input logic z, input bit lat);
    exp_t e;
    e.sum = s; e.c = c; e.o = o; e.z = z; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // Reference model in wide signed integer arithmetic.
  function automatic exp_t model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, r;
    logic [W:0]  u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_SUB || op == OP_SUBSAT) begin
      r   = sa - sb;
      e.c = (a >= b);
    end else begin
      r   = sa + sb;
      u   = {1'b0, a} + {1'b0, b};
      e.c = u[W];
    end
    e.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.sum = r[W-1:0];
    if ((op == OP_ADDSAT || op == OP_SUBSAT) && e.o)
      e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    e.z   = (e.sum == '0);
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  task automatic send(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    forever begin
      #3;
      if (bus.in_ready) begin
        e.acc = cyc;
        q.push_back(e);
        return;
      end
      n++;
      if (n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready stuck at 0, want 1 within 200 cycles");
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_rand(input logic [W-1:0] a, input logic [W-1:0] b, input op_e op);
    send(op, a, b, model(op, a, b));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending, want 0", q.size());
    end
  endtask

  // Monitor: compares on output transfer, checks hold while stalled.
  logic [W+2:0] held;
  bit           stalled = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        stalled = 0;
      end else begin
        if (stalled && bus.out_valid)
          check("hold_stable", 64'({bus.sum, bus.carry, bus.overflow, bus.zero}), 64'(held));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_result: got sum=%h with no beat outstanding, want none", bus.sum);
          end else begin
            e = q.pop_front();
            check("result{sum,c,o,z}", 64'({bus.sum, bus.carry, bus.overflow, bus.zero}),
                  64'({e.sum, e.c, e.o, e.z}));
            if (e.lat)
              check("latency", 64'(cyc - e.acc), 64'd4);
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        held    = {bus.sum, bus.carry, bus.overflow, bus.zero};
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    bus.op = OP_ADD;

    // Reset state
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outputs", 64'({bus.sum, bus.carry, bus.overflow, bus.zero}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed vectors, hand-computed results
    send(OP_ADD,    32'h0000_0001, 32'h0000_0002, mk(32'h0000_0003, 0, 0, 0, 1));
    idle();
    wait_drain();
    send(OP_ADD,    32'h00FF_FFFF, 32'h0000_0001, mk(32'h0100_0000, 0, 0, 0, 0));
    send(OP_ADD,    32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 1, 0));
    send(OP_SUB,    32'h0000_0005, 32'h0000_0007, mk(32'hFFFF_FFFE, 0, 0, 0, 0));
    send(OP_SUB,    32'h0000_0007, 32'h0000_0007, mk(32'h0000_0000, 1, 0, 1, 0));
    send(OP_SUB,    32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1, 1, 0, 0));
    send(OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 1, 0, 0));
    send(OP_ADDSAT, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h7FFF_FFFF, 0, 1, 0, 0));
    send(OP_SUBSAT, 32'h8000_0000, 32'h0000_0001, mk(32'h8000_0000, 1, 1, 0, 0));
    send(OP_ADDSAT, 32'h0000_0003, 32'h0000_0004, mk(32'h0000_0007, 0, 0, 0, 0));
    send(OP_SUBSAT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, mk(32'h7FFF_FFFF, 0, 1, 0, 0));
    send(OP_ADDSAT, 32'h8000_0000, 32'h8000_0000, mk(32'h8000_0000, 1, 1, 0, 0));
    send(OP_SUBSAT, 32'h0000_0000, 32'h0000_0000, mk(32'h0000_0000, 1, 0, 1, 0));
    send(OP_SUB,    32'h0000_0100, 32'h0000_0001, mk(32'h0000_00FF, 1, 0, 0, 0));
    idle();
    wait_drain();

    // Fill with the output stalled: in_ready must drop after 4 beats
    ready_mode = 1;
    for (int i = 0; i < 4; i++)
      send_rand($urandom, $urandom, op_e'($urandom_range(0, 3)));
    idle();
    #3;
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);

    // Back-to-back stream with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0)
        send_rand(32'h7FFF_FFF0 + 32'($urandom_range(0, 31)), 32'($urandom_range(0, 63)),
                  op_e'($urandom_range(0, 3)));
      else if (i % 4 == 1)
        send_rand(32'h8000_0000 + 32'($urandom_range(0, 15)), 32'($urandom_range(0, 63)),
                  op_e'($urandom_range(0, 3)));
      else
        send_rand($urandom, $urandom, op_e'($urandom_range(0, 3)));
    end
    idle();
    ready_mode = 0;
    wait_drain();

    // Reset with 3 beats in flight
    ready_mode = 1;
    for (int i = 0; i < 3; i++)
      send_rand($urandom, $urandom, OP_ADD);
    idle();
    repeat (5) @(negedge clk);
    #3;
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_outputs", 64'({bus.sum, bus.carry, bus.overflow, bus.zero}), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    end
    send(OP_SUB, 32'h0000_1000, 32'h0000_0001, mk(32'h0000_0FFF, 1, 0, 0, 1));
    idle();
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want completion before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end

endmodule
`default_nettype wire
